// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, requests instruction memory, presents instr/pc to decode.
// Optional misaligned-target trap to TRAP_VEC when built with MISALIGN_TRAP_EN defined.
module pc_fetch_unit #(
    parameter int unsigned    n         = 32,
    parameter logic [n-1:0]   RESET_PC  = '0,
    parameter logic [n-1:0]   NOP_INSTR = 'h13
`ifdef MISALIGN_TRAP_EN
    ,
    parameter logic [n-1:0]   TRAP_VEC  = 'h100
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic [1:0]   pc_src,
    input  logic [n-1:0] imm_ext,
    input  logic [n-1:0] alu_result,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic [n-1:0] imem_rdata,
    input  logic         imem_valid,
    output logic [n-1:0] instr,
    output logic         instr_valid,
    output logic [n-1:0] pc,
    output logic [n-1:0] pc_plus4
`ifdef MISALIGN_TRAP_EN
    ,
    output logic         misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic [n-1:0] instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         misalign_err_q, misalign_err_d;
    logic [n-1:0] next_pc;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        misalign_err_d = 1'b0;

        // Reserved encoding 11 falls through to sequential PC+4.
        unique case (pc_src)
            2'b01:   next_pc = pc_q + imm_ext;
            2'b10:   next_pc = alu_result & ~n'(1);
            default: next_pc = pc_q + n'(4);
        endcase

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_valid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_d          = next_pc;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
`ifdef MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        pc_d           = TRAP_VEC;
                        misalign_err_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= NOP_INSTR;
            instr_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + n'(4);

`ifdef MISALIGN_TRAP_EN
    assign misalign_err = misalign_err_q;
`else
    // Trap flag is only observable when the trap feature is built in.
    logic unused_misalign;
    assign unused_misalign = misalign_err_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; memory returns addr ^ MAGIC so instr is predictable.
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ MAGIC;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH with memory ready; leaves one cycle after the EXEC advance.
    task automatic run_instr(input logic [31:0] exp_pc, input logic [1:0] src,
                             input logic [31:0] imm, input logic [31:0] alu);
        check("fetch_req", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_pc);
        check("fetch_valid", {31'b0, instr_valid}, 32'd0);
        check("fetch_nop", instr, NOP);
`ifdef MISALIGN_TRAP_EN
        check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_err});
`endif
        exp_err = 1'b0;
        tick();
        check("exec_valid", {31'b0, instr_valid}, 32'd1);
        check("exec_req", {31'b0, imem_req}, 32'd0);
        check("exec_instr", instr, exp_pc ^ MAGIC);
        check("exec_pc", pc, exp_pc);
        check("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
`ifdef MISALIGN_TRAP_EN
        check("misalign_exec", {31'b0, misalign_err}, 32'd0);
`endif
        pc_src     = src;
        imm_ext    = imm;
        alu_result = alu;
        tick();
        pc_src     = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic [31:0] q;
        rst        = 1'b1;
        stall      = 1'b0;
        pc_src     = 2'b00;
        imm_ext    = '0;
        alu_result = '0;
        imem_valid = 1'b1;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, NOP);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        tick();

        // Sequential fetch, then branches forward/backward, reserved select and JALR.
        run_instr(32'h00, 2'b00, '0, '0);
        run_instr(32'h04, 2'b00, '0, '0);
        run_instr(32'h08, 2'b00, '0, '0);
        run_instr(32'h0C, 2'b00, '0, '0);
        run_instr(32'h10, 2'b01, 32'hFFFF_FFF8, '0);
        run_instr(32'h08, 2'b01, 32'h0000_0008, '0);
        run_instr(32'h10, 2'b01, 32'h0000_0020, '0);
        run_instr(32'h30, 2'b11, 32'h0000_0100, 32'h0000_0400);
        run_instr(32'h34, 2'b10, '0, 32'h0000_0205);
        run_instr(32'h204, 2'b10, '0, 32'h0000_0203);
`ifdef MISALIGN_TRAP_EN
        exp_err = 1'b1;
        run_instr(32'h100, 2'b10, '0, 32'h0000_0102);
        exp_err = 1'b1;
        run_instr(32'h100, 2'b00, '0, '0);
        p = 32'h104;
`else
        run_instr(32'h202, 2'b10, '0, 32'h0000_0102);
        run_instr(32'h102, 2'b00, '0, '0);
        p = 32'h106;
`endif

        // Memory wait with stall asserted during FETCH (no effect there).
        imem_valid = 1'b0;
        stall      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, p);
            check("wait_valid", {31'b0, instr_valid}, 32'd0);
            tick();
        end
        check("wait_req_end", {31'b0, imem_req}, 32'd1);
        check("wait_addr_end", imem_addr, p);
        imem_valid = 1'b1;
        tick();
        check("wait_done_valid", {31'b0, instr_valid}, 32'd1);
        check("wait_done_instr", instr, p ^ MAGIC);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_pc", pc, p);
            check("stall_instr", instr, p ^ MAGIC);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        q = p + 32'd4;

        // Jump to the top of the address space and wrap through PC+4.
        run_instr(q, 2'b01, 32'hFFFF_FFFC - q, '0);
        run_instr(32'hFFFF_FFFC, 2'b00, '0, '0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc_plus4", pc_plus4, 32'h4);

        // Reset lands while a response is returning in FETCH.
        rst        = 1'b1;
        imem_valid = 1'b1;
        tick();
        check("midrst_pc", pc, 32'h0);
        check("midrst_instr", instr, NOP);
        check("midrst_valid", {31'b0, instr_valid}, 32'd0);
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        tick();
        check("late_valid_ignored", {31'b0, instr_valid}, 32'd0);
        check("late_instr_nop", instr, NOP);
        run_instr(32'h00, 2'b00, '0, '0);
        check("final_addr", imem_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the immediate sign extender.
- Holds the program counter and issues requests to instruction memory.
- Latches the returned instruction word and presents it, together with its PC, to decode and the sign extender.
- Computes the next PC from the sign-extended immediate (branch/JAL) or the ALU result (JALR), with a stall hold.

Parameters:
- n, 32, datapath/address width in bits.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction word presented while nothing valid is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold current instruction and PC; no advance while high.
- pc_src  input  2  next-PC select: 00 PC+4, 01 PC+imm_ext, 10 JALR target, 11 reserved (treated as 00).
- imm_ext  input  n  sign-extended immediate from the sign extender.
- alu_result  input  n  ALU sum rs1+imm, used for the JALR target.
- imem_req  output  1  fetch request strobe.
- imem_addr  output  n  fetch address; equals pc.
- imem_rdata  input  n  instruction word returned by memory.
- imem_valid  input  1  imem_rdata valid this cycle.
- instr  output  n  latched instruction to decode/sign extender.
- instr_valid  output  1  instr is a real fetched instruction.
- pc  output  n  address of instr.
- pc_plus4  output  n  pc+4, for JAL/JALR link value.

Behaviour:
- Reset values: pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, state=IDLE. Reset has priority over every other event, including an in-flight fetch; a late imem_valid after reset is ignored.
- States:
  - IDLE: one cycle after reset deasserts, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc. imem_valid ignored outside FETCH.
    - On imem_valid=1: instr<=imem_rdata; instr_valid<=1 next cycle; go EXEC.
    - imem_valid=0: remain in FETCH, request held, address stable.
  - EXEC: imem_req=0, instr_valid=1, instr and pc stable.
    - stall=1: hold everything.
    - stall=0: pc<=next_pc; instr_valid<=0; instr<=NOP_INSTR; go FETCH.
- Minimum latency: memory responding same cycle as the request gives 2 cycles per instruction (FETCH, EXEC).
- stall during FETCH has no effect; stall only holds in EXEC.
- next_pc is combinational from pc, pc_src, imm_ext and alu_result, sampled on the EXEC advance edge:
  - 00/11: pc+4.
  - 01: pc+imm_ext.
  - 10: alu_result with bit 0 cleared.
- Arithmetic: all additions modulo 2^n, no carry out.
  - 32'hFFFFFFFC+4 = 0.
  - pc+negative imm wraps naturally.
- pc_plus4 = pc+4 at all times, same wrap rule.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled:
  - Extra parameter TRAP_VEC (default 32'h00000100) and extra output misalign_err (1 bit, reset 0).
  - At the EXEC advance, if next_pc[1:0] != 00: pc<=TRAP_VEC and misalign_err pulses high for exactly one cycle (the cycle after the advance edge).
- Disabled: no extra port or parameter; next_pc[1:0] is loaded unchanged, so a misaligned PC is fetched as-is.

Test Plan:
- Reset then sequential: rst 1 for 2 cycles, memory always valid -> imem_addr sequence 0,4,8,C; instr_valid high every 2nd cycle; pc_plus4 = pc+4.
- Branch: pc=0x10, imm_ext=0xFFFFFFF8, pc_src=01 -> next imem_addr=0x08. imm_ext=0x20 -> next imem_addr=0x30.
- JALR: alu_result=0x00000203, pc_src=10 -> next imem_addr=0x202.
- Memory wait + stall: imem_valid delayed 3 cycles -> imem_req and imem_addr held stable. Then stall=1 for 4 cycles in EXEC -> instr/pc unchanged, no request; advance on the cycle stall drops.
- Wrap + reset mid-fetch: pc=0xFFFFFFFC, pc_src=00 -> next pc=0. rst asserted in FETCH with imem_valid the same cycle -> pc=RESET_PC, instr=0x00000013, instr_valid=0.
- MISALIGN_TRAP_EN: pc_src=10, alu_result=0x102 -> pc=0x100, misalign_err high exactly 1 cycle. Without the macro -> pc=0x102.
